hps_cmd_interface: RTL and testbench
====================================

Name: hps_cmd_interface

Overview:
HPS-to-FPGA command register block. It is the write-side counterpart of the FPGA-to-HPS readback registers. The HPS writes operands, an opcode and a START command through a simple register write port. The block snapshots the operands, issues a one-cycle start to the calculator ALU, waits for done with a timeout, then captures the result and sticky status flags for HPS readback.

Parameters:
DATA_W, 16, width of operands, opcode, result and register data
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before a timeout is declared (≥2)
CNT_W, 11, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
writeEnable  input  1  HPS register write strobe, one write per cycle
writeAddress  input  4  register index for write
writeData  input  DATA_W  write data
readAddress  input  4  register index for read
readData  output  DATA_W  combinational read data
alu_a  output  DATA_W  operand a snapshot
alu_b  output  DATA_W  operand b snapshot
alu_op  output  DATA_W  opcode snapshot
alu_start  output  1  one-cycle start pulse to ALU
alu_done  input  1  ALU completion pulse
alu_result  input  DATA_W  ALU result, valid when alu_done=1
alu_error  input  1  ALU error flag (e.g. divide by zero), valid with alu_done
busy  output  1  high while state is not IDLE

Behaviour:
- Register map:
  - 0 A (RW)
  - 1 B (RW)
  - 2 OPCODE (RW)
  - 3 CTRL (write-only; reads 0): bit0 START, bit1 CLEAR
  - 4 RESULT (RO)
  - 5 STATUS (RO): bit0 busy, bit1 done, bit2 error, bit3 timeout, bit4 overrun, others 0
  - addresses 6-15 read 0; writes to RO or unmapped addresses are ignored.
- Reset (rst=0, async): all registers, snapshots, RESULT, flags and counter go to 0; state=IDLE; alu_start=0; busy=0. Reset asserted mid-operation aborts immediately. A later alu_done is ignored because state is IDLE.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: a write to CTRL with bit0=1 at edge N does the following at that edge: copies A/B/OPCODE into the alu_a/b/op snapshots (a same-cycle write to A/B/OPCODE is not included; the old value is snapshotted), clears done/error/timeout, and moves to ISSUE.
  - ISSUE: alu_start=1 for exactly this one cycle; counter cleared; goes to WAIT next edge.
  - WAIT:
    - On alu_done=1: RESULT<=alu_result, error<=alu_error, done<=1, go to IDLE.
    - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 without done: timeout<=1, done<=1, RESULT unchanged, go to IDLE.
    - alu_done on the timeout cycle wins: it is a normal completion.
- alu_done while in IDLE or ISSUE is ignored.
- busy = (state != IDLE); STATUS bit0 mirrors busy.
- START while busy: ignored, overrun<=1, snapshots unchanged. A/B/OPCODE writes while busy are accepted into the registers but do not affect the running snapshot.
- CLEAR (bit1) clears done/error/timeout/overrun.
  - CLEAR together with START in IDLE: the clear applies, then the start proceeds.
  - CLEAR while busy clears only the overrun flag.
- Start-to-issue latency: START written at edge N, alu_start high in cycle N+1. Minimum turnaround from done to the next accepted START is 1 cycle.
- readData is purely combinational from readAddress; no read side effects.
- snapshots hold their value after completion until the next accepted START.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, release -> readData=0 at all addresses 0-15, alu_start=0, busy=0.
- Normal operation: write A=0x0012, B=0x0034, OPCODE=0x0001, CTRL=0x0001 -> one-cycle alu_start, alu_a=0x0012, alu_b=0x0034, alu_op=0x0001. ALU returns done after 5 cycles with result 0x0046 -> RESULT=0x0046, STATUS=0x0002, busy=0.
- Error and overrun: start; while busy write CTRL=0x0001 -> STATUS=0x0011, single alu_start only. ALU then returns done with alu_error=1 -> STATUS=0x0016. Write CTRL=0x0002 -> STATUS=0x0000.
- Timeout (TIMEOUT_CYCLES=8): start and never assert alu_done -> exactly 8 cycles in WAIT, then STATUS=0x000A and RESULT keeps its previous value. A late alu_done pulse is ignored.
- Snapshot isolation: start with A=5; write A=9 during WAIT -> alu_a stays 5 and register 0 reads 9. The next START drives alu_a=9.
- Async reset in WAIT: drop rst mid-wait without a clock edge -> busy=0 immediately. alu_done after release leaves STATUS=0.

Source files
------------

// File: rtl/hps_cmd_interface.sv
// hps_cmd_interface: HPS register write port that snapshots ALU operands, issues a start pulse
// and captures the result/status with a done timeout.  Rev 1.0
`default_nettype none

module hps_cmd_interface #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeEnable,
  input  logic [3:0]        writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic [3:0]        readAddress,
  output logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_error,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic [DATA_W-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d, snap_op_q, snap_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d, err_q, err_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic w_wr_ctrl, w_start_req, w_clear_req;

  assign w_wr_ctrl   = writeEnable && (writeAddress == 4'd3);
  assign w_start_req = w_wr_ctrl && writeData[0];
  assign w_clear_req = w_wr_ctrl && writeData[1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    snap_a_d  = snap_a_q;
    snap_b_d  = snap_b_q;
    snap_op_d = snap_op_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;

    // Operand registers are writable in every state; only the snapshots are protected.
    if (writeEnable) begin
      case (writeAddress)
        4'd0:    a_d  = writeData;
        4'd1:    b_d  = writeData;
        4'd2:    op_d = writeData;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (w_clear_req) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          tmo_d  = 1'b0;
          ovr_d  = 1'b0;
        end
        if (w_start_req) begin
          snap_a_d  = a_q;
          snap_b_d  = b_q;
          snap_op_d = op_q;
          done_d    = 1'b0;
          err_d     = 1'b0;
          tmo_d     = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          err_d    = alu_error;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // While busy, CLEAR only touches overrun and a START is recorded as overrun.
    if (state_q != S_IDLE) begin
      if (w_clear_req) ovr_d = 1'b0;
      if (w_start_req) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      snap_op_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_op_q <= snap_op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign alu_start = (state_q == S_ISSUE);
  assign alu_a     = snap_a_q;
  assign alu_b     = snap_b_q;
  assign alu_op    = snap_op_q;

  always_comb begin
    readData = '0;
    case (readAddress)
      4'd0:    readData = a_q;
      4'd1:    readData = b_q;
      4'd2:    readData = op_q;
      4'd4:    readData = result_q;
      4'd5:    readData = {{(DATA_W-5){1'b0}}, ovr_q, tmo_q, err_q, done_q, busy};
      default: readData = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hps_cmd_interface.sv
// tb_hps_cmd_interface: directed self-checking bench for hps_cmd_interface (TIMEOUT_CYCLES=8).  Rev 1.0
`default_nettype none

module tb_hps_cmd_interface;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              writeEnable;
  logic [3:0]        writeAddress;
  logic [DATA_W-1:0] writeData;
  logic [3:0]        readAddress;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] alu_a, alu_b, alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              alu_error;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int start_pulses = 0;

  hps_cmd_interface #(
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (writeEnable),
    .writeAddress(writeAddress),
    .writeData   (writeData),
    .readAddress (readAddress),
    .readData    (readData),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .alu_error   (alu_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start === 1'b1) start_pulses <= start_pulses + 1;

  // Drive one register write at the next rising edge; returns at the following falling edge.
  task automatic wr(input logic [3:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    writeEnable  = 1'b1;
    writeAddress = addr;
    writeData    = data;
    @(negedge clk);
    writeEnable  = 1'b0;
    writeAddress = 4'd0;
    writeData    = '0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [DATA_W-1:0] data);
    readAddress = addr;
    #1;
    data = readData;
  endtask

  // Wait n falling edges, then present alu_done for exactly one rising edge.
  task automatic alu_respond(input int n, input logic [DATA_W-1:0] res, input logic err);
    repeat (n) @(negedge clk);
    alu_done   = 1'b1;
    alu_result = res;
    alu_error  = err;
    @(negedge clk);
    alu_done   = 1'b0;
    alu_result = '0;
    alu_error  = 1'b0;
  endtask

  task automatic test_reset;
    logic [DATA_W-1:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      total++;
      if (v !== 16'h0000) begin
        bad++;
        $display("FAIL reset_read addr=%0d actual=%h required=0000", i, v);
      end
    end
    total++;
    if (alu_start !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs actual start=%b busy=%b required start=0 busy=0", alu_start, busy);
    end
  endtask

  task automatic test_normal;
    logic [DATA_W-1:0] v;
    int p0;
    wr(4'd0, 16'h0012);
    wr(4'd1, 16'h0034);
    wr(4'd2, 16'h0001);
    p0 = start_pulses;
    wr(4'd3, 16'h0001);
    total++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL normal_issue actual start=%b busy=%b required start=1 busy=1", alu_start, busy);
    end
    total++;
    if (alu_a !== 16'h0012 || alu_b !== 16'h0034 || alu_op !== 16'h0001) begin
      bad++;
      $display("FAIL normal_snapshot actual a=%h b=%h op=%h required a=0012 b=0034 op=0001", alu_a, alu_b, alu_op);
    end
    alu_respond(5, 16'h0046, 1'b0);
    rd(4'd4, v);
    total++;
    if (v !== 16'h0046) begin
      bad++;
      $display("FAIL normal_result actual=%h required=0046", v);
    end
    rd(4'd5, v);
    total++;
    if (v !== 16'h0002 || busy !== 1'b0) begin
      bad++;
      $display("FAIL normal_status actual=%h busy=%b required=0002 busy=0", v, busy);
    end
    total++;
    if (start_pulses - p0 !== 1) begin
      bad++;
      $display("FAIL normal_pulses actual=%0d required=1", start_pulses - p0);
    end
  endtask

  task automatic test_error_overrun;
    logic [DATA_W-1:0] v;
    int p0;
    p0 = start_pulses;
    wr(4'd3, 16'h0001);
    wr(4'd3, 16'h0001);
    rd(4'd5, v);
    total++;
    if (v !== 16'h0011) begin
      bad++;
      $display("FAIL overrun_status actual=%h required=0011", v);
    end
    alu_respond(2, 16'h00EE, 1'b1);
    rd(4'd5, v);
    total++;
    if (v !== 16'h0016) begin
      bad++;
      $display("FAIL error_status actual=%h required=0016", v);
    end
    total++;
    if (start_pulses - p0 !== 1) begin
      bad++;
      $display("FAIL overrun_pulses actual=%0d required=1", start_pulses - p0);
    end
    wr(4'd3, 16'h0002);
    rd(4'd5, v);
    total++;
    if (v !== 16'h0000) begin
      bad++;
      $display("FAIL clear_status actual=%h required=0000", v);
    end
  endtask

  task automatic test_timeout;
    logic [DATA_W-1:0] v;
    int wait_cycles;
    wait_cycles = 0;
    wr(4'd3, 16'h0001);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      wait_cycles++;
    end
    total++;
    if (wait_cycles !== 8) begin
      bad++;
      $display("FAIL timeout_wait_cycles actual=%0d required=8", wait_cycles);
    end
    rd(4'd5, v);
    total++;
    if (v !== 16'h000A) begin
      bad++;
      $display("FAIL timeout_status actual=%h required=000a", v);
    end
    rd(4'd4, v);
    total++;
    if (v !== 16'h00EE) begin
      bad++;
      $display("FAIL timeout_result actual=%h required=00ee", v);
    end
    alu_respond(1, 16'h5555, 1'b1);
    rd(4'd5, v);
    total++;
    if (v !== 16'h000A) begin
      bad++;
      $display("FAIL late_done_status actual=%h required=000a", v);
    end
    rd(4'd4, v);
    total++;
    if (v !== 16'h00EE) begin
      bad++;
      $display("FAIL late_done_result actual=%h required=00ee", v);
    end
  endtask

  task automatic test_done_on_timeout_edge;
    logic [DATA_W-1:0] v;
    wr(4'd3, 16'h0001);
    // Eight falling edges after ISSUE puts the counter at its last value.
    alu_respond(8, 16'h0BEE, 1'b0);
    rd(4'd5, v);
    total++;
    if (v !== 16'h0002) begin
      bad++;
      $display("FAIL edge_done_status actual=%h required=0002", v);
    end
    rd(4'd4, v);
    total++;
    if (v !== 16'h0BEE) begin
      bad++;
      $display("FAIL edge_done_result actual=%h required=0bee", v);
    end
  endtask

  task automatic test_snapshot_isolation;
    logic [DATA_W-1:0] v;
    wr(4'd0, 16'h0005);
    wr(4'd3, 16'h0001);
    wr(4'd0, 16'h0009);
    total++;
    if (alu_a !== 16'h0005 || busy !== 1'b1) begin
      bad++;
      $display("FAIL snap_hold actual a=%h busy=%b required a=0005 busy=1", alu_a, busy);
    end
    rd(4'd0, v);
    total++;
    if (v !== 16'h0009) begin
      bad++;
      $display("FAIL snap_reg_a actual=%h required=0009", v);
    end
    alu_respond(1, 16'h0001, 1'b0);
    total++;
    if (alu_a !== 16'h0005) begin
      bad++;
      $display("FAIL snap_after_done actual=%h required=0005", alu_a);
    end
    wr(4'd3, 16'h0001);
    total++;
    if (alu_a !== 16'h0009) begin
      bad++;
      $display("FAIL snap_next_start actual=%h required=0009", alu_a);
    end
    alu_respond(1, 16'h0002, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] v;
    // Done edge followed directly by a CLEAR+START write on the next edge.
    wr(4'd3, 16'h0001);
    @(negedge clk);
    alu_done     = 1'b1;
    alu_result   = 16'h0077;
    @(negedge clk);
    alu_done     = 1'b0;
    writeEnable  = 1'b1;
    writeAddress = 4'd3;
    writeData    = 16'h0003;
    @(negedge clk);
    writeEnable  = 1'b0;
    writeData    = '0;
    rd(4'd5, v);
    total++;
    if (v !== 16'h0001 || alu_start !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart actual status=%h start=%b required status=0001 start=1", v, alu_start);
    end
    alu_respond(1, 16'h0078, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [DATA_W-1:0] v;
    wr(4'd3, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || alu_start !== 1'b0) begin
      bad++;
      $display("FAIL async_reset actual busy=%b start=%b required busy=0 start=0", busy, alu_start);
    end
    @(negedge clk);
    rst = 1'b1;
    alu_respond(1, 16'h1234, 1'b1);
    rd(4'd5, v);
    total++;
    if (v !== 16'h0000) begin
      bad++;
      $display("FAIL async_late_done actual=%h required=0000", v);
    end
    rd(4'd4, v);
    total++;
    if (v !== 16'h0000) begin
      bad++;
      $display("FAIL async_result actual=%h required=0000", v);
    end
  endtask

  initial begin
    rst          = 1'b1;
    writeEnable  = 1'b0;
    writeAddress = 4'd0;
    writeData    = '0;
    readAddress  = 4'd0;
    alu_done     = 1'b0;
    alu_result   = '0;
    alu_error    = 1'b0;
    test_reset();
    test_normal();
    test_error_overrun();
    test_timeout();
    test_done_on_timeout_edge();
    test_snapshot_isolation();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
